// File: rtl/hilo_pkg.sv
// hilo_pkg -- shared definitions for the HI/LO register unit.
//   * R-type funct codes handled by hi_lo_unit
//   * FSM state type for hi_lo_unit
//   * is_hilo_funct(): true for any funct the unit decodes
// Optional feature macro: HILO_SIGNED_MULT_EN (adds MULT and the FIX state).
package hilo_pkg;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULTU = 6'h19;
`ifdef HILO_SIGNED_MULT_EN
    localparam logic [5:0] FN_MULT  = 6'h18;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIX} hilo_state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} hilo_state_t;
`endif

    function automatic logic is_hilo_funct(input logic [5:0] f);
        case (f)
            FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO, FN_MULTU: return 1'b1;
`ifdef HILO_SIGNED_MULT_EN
            FN_MULT: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_sign_fix.sv
// hilo_sign_fix -- sign handling for signed MULT on an unsigned multiplier.
// Used by hi_lo_unit only when HILO_SIGNED_MULT_EN is defined.
// Ports:
//   rs_data, rt_data  in  signed operands
//   product           in  2*DATA_W value to negate (current {HI,LO})
//   mag_a, mag_b      out operand magnitudes (most-negative maps to itself,
//                         which is the correct unsigned magnitude)
//   sign              out rs[MSB] ^ rt[MSB]
//   neg_product       out two's-complement negation of product
module hilo_sign_fix #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]   rs_data,
    input  logic [DATA_W-1:0]   rt_data,
    input  logic [2*DATA_W-1:0] product,
    output logic [DATA_W-1:0]   mag_a,
    output logic [DATA_W-1:0]   mag_b,
    output logic                sign,
    output logic [2*DATA_W-1:0] neg_product
);

    always_comb begin
        mag_a       = rs_data[DATA_W-1] ? (~rs_data + DATA_W'(1)) : rs_data;
        mag_b       = rt_data[DATA_W-1] ? (~rt_data + DATA_W'(1)) : rt_data;
        sign        = rs_data[DATA_W-1] ^ rt_data[DATA_W-1];
        neg_product = ~product + (2*DATA_W)'(1);
    end

endmodule

// File: rtl/hi_lo_unit.sv
// hi_lo_unit -- HI/LO register file with multiplier handshake for an EX stage.
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-low reset
//   op_valid, op_funct      EX-stage instruction valid and R-type funct
//   rs_data, rt_data        operands / move source
//   rd_data                 MFHI/MFLO result (0 when no move-from in IDLE)
//   stall                   freeze pipeline while a multiply is in flight
//   err                     sticky multiplier timeout flag
//   mul_start, mul_a, mul_b start pulse and operands to the multiplier
//   mul_done, mul_product   product-valid pulse and 2*DATA_W product
// Optional feature macro: HILO_SIGNED_MULT_EN -- decodes MULT (6'h18), sends
// operand magnitudes and corrects the sign in an extra FIX state.
module hi_lo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [5:0]          op_funct,
    input  logic [DATA_W-1:0]   rs_data,
    input  logic [DATA_W-1:0]   rt_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                stall,
    output logic                err,
    output logic                mul_start,
    output logic [DATA_W-1:0]   mul_a,
    output logic [DATA_W-1:0]   mul_b,
    input  logic                mul_done,
    input  logic [2*DATA_W-1:0] mul_product
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    hilo_state_t       state;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [CNT_W-1:0]  wait_cnt;

`ifdef HILO_SIGNED_MULT_EN
    logic                signed_op_q;
    logic                sign_q;
    logic                op_sign;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [2*DATA_W-1:0] neg_hilo;

    hilo_sign_fix #(.DATA_W(DATA_W)) u_sign_fix (
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .product     ({hi_q, lo_q}),
        .mag_a       (mag_a),
        .mag_b       (mag_b),
        .sign        (op_sign),
        .neg_product (neg_hilo)
    );
`endif

    // Any decoded op must wait while a multiply is outstanding; reads are
    // only served from IDLE so they always see the final HI/LO.
    always_comb begin
        stall   = op_valid && is_hilo_funct(op_funct) && (state != ST_IDLE);
        rd_data = '0;
        if (state == ST_IDLE && op_valid) begin
            if (op_funct == FN_MFHI)
                rd_data = hi_q;
            else if (op_funct == FN_MFLO)
                rd_data = lo_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            err       <= 1'b0;
            wait_cnt  <= '0;
`ifdef HILO_SIGNED_MULT_EN
            signed_op_q <= 1'b0;
            sign_q      <= 1'b0;
`endif
        end else begin
            mul_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op_funct)
                            FN_MULTU: begin
                                mul_a     <= rs_data;
                                mul_b     <= rt_data;
                                mul_start <= 1'b1;
                                state     <= ST_ISSUE;
`ifdef HILO_SIGNED_MULT_EN
                                signed_op_q <= 1'b0;
`endif
                            end
`ifdef HILO_SIGNED_MULT_EN
                            FN_MULT: begin
                                mul_a       <= mag_a;
                                mul_b       <= mag_b;
                                sign_q      <= op_sign;
                                signed_op_q <= 1'b1;
                                mul_start   <= 1'b1;
                                state       <= ST_ISSUE;
                            end
`endif
                            FN_MTHI: hi_q <= rs_data;
                            FN_MTLO: lo_q <= rs_data;
                            default: ;
                        endcase
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done in the final counted cycle still wins over timeout.
                    if (mul_done) begin
                        hi_q     <= mul_product[2*DATA_W-1:DATA_W];
                        lo_q     <= mul_product[DATA_W-1:0];
                        wait_cnt <= '0;
`ifdef HILO_SIGNED_MULT_EN
                        state    <= signed_op_q ? ST_FIX : ST_IDLE;
`else
                        state    <= ST_IDLE;
`endif
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        err      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
`ifdef HILO_SIGNED_MULT_EN
                ST_FIX: begin
                    if (sign_q) begin
                        hi_q <= neg_hilo[2*DATA_W-1:DATA_W];
                        lo_q <= neg_hilo[DATA_W-1:0];
                    end
                    state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hi_lo_unit.sv
// tb_hi_lo_unit -- self-checking bench for hi_lo_unit.
// A transaction-level model (busy flag, age since acceptance) predicts every
// output each cycle; directed sequences add literal expectations.
// Honours HILO_SIGNED_MULT_EN when defined.
module tb_hi_lo_unit;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 64;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          op_valid = 1'b0;
    logic [5:0]    op_funct = '0;
    logic [DW-1:0] rs_data = '0;
    logic [DW-1:0] rt_data = '0;
    logic [DW-1:0] rd_data;
    logic          stall;
    logic          err;
    logic          mul_start;
    logic [DW-1:0] mul_a;
    logic [DW-1:0] mul_b;
    logic          mul_done = 1'b0;
    logic [2*DW-1:0] mul_product = '0;

    always #5 clk = ~clk;

    hi_lo_unit #(.DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_funct    (op_funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .rd_data     (rd_data),
        .stall       (stall),
        .err         (err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_product (mul_product)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          busy, fixing, is_signed, negate, m_err;
    int          age;
    logic [31:0] m_hi, m_lo, m_a, m_b;

    function automatic bit known(input logic [5:0] f);
        if (f inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULTU}) return 1'b1;
`ifdef HILO_SIGNED_MULT_EN
        if (f == F_MULT) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic model_reset();
        busy = 0; fixing = 0; is_signed = 0; negate = 0; m_err = 0; age = 0;
        m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
    endtask

    // Compare outputs, then advance the model across the coming rising edge.
    always @(negedge clk) begin
        bit          e_stall;
        logic [31:0] e_rd;
        logic [63:0] hl;
        if (!reset) model_reset();
        e_stall = busy && op_valid && known(op_funct);
        e_rd = '0;
        if (!busy && op_valid) begin
            if (op_funct == F_MFHI) e_rd = m_hi;
            else if (op_funct == F_MFLO) e_rd = m_lo;
        end
        check("stall", stall, e_stall);
        if (!e_stall) check("rd_data", rd_data, e_rd);
        check("mul_start", mul_start, busy && age == 0);
        check("mul_a", mul_a, m_a);
        check("mul_b", mul_b, m_b);
        check("err", err, m_err);

        if (!reset) model_reset();
        else if (!busy) begin
            if (op_valid) begin
                case (op_funct)
                    F_MULTU: begin busy = 1; age = 0; m_a = rs_data; m_b = rt_data; is_signed = 0; end
`ifdef HILO_SIGNED_MULT_EN
                    F_MULT: begin
                        busy = 1; age = 0; is_signed = 1;
                        m_a = rs_data[31] ? 32'(0 - rs_data) : rs_data;
                        m_b = rt_data[31] ? 32'(0 - rt_data) : rt_data;
                        negate = rs_data[31] ^ rt_data[31];
                    end
`endif
                    F_MTHI: m_hi = rs_data;
                    F_MTLO: m_lo = rs_data;
                    default: ;
                endcase
            end
        end else if (fixing) begin
            if (negate) begin
                hl = 64'(0) - {m_hi, m_lo};
                {m_hi, m_lo} = hl;
            end
            busy = 0; fixing = 0;
        end else if (age == 0) begin
            age = 1;
        end else if (mul_done) begin
            {m_hi, m_lo} = mul_product;
            if (is_signed) fixing = 1; else busy = 0;
        end else if (age == TO) begin
            m_err = 1; busy = 0;
        end else begin
            age++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit v, input logic [5:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit d, input logic [63:0] p);
        @(posedge clk);
        #1;
        op_valid = v; op_funct = f; rs_data = a; rt_data = b;
        mul_done = d; mul_product = p;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 6'h00, '0, '0, 0, '0);
    endtask

    initial begin
        int          done_pct;
        logic [5:0]  f;
        logic [5:0]  fsel [7];
        fsel = '{F_MFHI, F_MTHI, F_MFLO, F_MTLO, F_MULTU, F_MULT, 6'h00};

        repeat (3) @(posedge clk);
        #1;
        check("rst_err", err, 0);
        check("rst_start", mul_start, 0);
        check("rst_mul_a", mul_a, 0);
        reset = 1'b1;

        // MULTU FFFFFFFF x 2, product after 33 cycles, then MFLO
        drive(1, F_MULTU, 32'hFFFF_FFFF, 32'h2, 0, '0);
        idle(32);
        drive(0, 6'h00, '0, '0, 1, 64'h1_FFFF_FFFE);
        drive(1, F_MFLO, '0, '0, 0, '0);
        #3;
        check("req24_rd_lo", rd_data, 32'hFFFF_FFFE);
        check("req24_model_hi", m_hi, 32'h1);
        drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("req24_rd_hi", rd_data, 32'h1);

        // MTHI then MFHI
        drive(1, F_MTHI, 32'hDEAD_BEEF, '0, 0, '0);
        #3;
        check("req26_stall_mt", stall, 0);
        drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("req26_rd", rd_data, 32'hDEAD_BEEF);
        check("req26_stall_mf", stall, 0);

        // Timeout, then a late done is ignored
        drive(1, F_MULTU, 32'h3, 32'h4, 0, '0);
        idle(70);
        #3;
        check("req27_err", err, 1);
        check("req27_model_err", m_err, 1);
        drive(0, 6'h00, '0, '0, 1, 64'h1234_5678_9ABC_DEF0);
        drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("req27_hi", rd_data, 32'hDEAD_BEEF);
        drive(1, F_MFLO, '0, '0, 0, '0);
        #3;
        check("req27_lo", rd_data, 32'hFFFF_FFFE);

        // MFHI held during WAIT
        drive(1, F_MULTU, 32'h7, 32'h6, 0, '0);
        for (int i = 0; i < 9; i++) drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("req25_stall_wait", stall, 1);
        drive(1, F_MFHI, '0, '0, 1, 64'h0000_0005_0000_002A);
        #3;
        check("req25_stall_done", stall, 1);
        drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("req25_stall_after", stall, 0);
        check("req25_rd", rd_data, 32'h5);

        // Back-to-back MULTU
        drive(1, F_MULTU, 32'h10, 32'h20, 0, '0);
        idle(3);
        drive(1, F_MULTU, 32'h11, 32'h22, 1, 64'h200);
        #3;
        check("req17_stall_done", stall, 1);
        drive(1, F_MULTU, 32'h11, 32'h22, 0, '0);
        #3;
        check("req17_accept", stall, 0);
        drive(0, 6'h00, '0, '0, 0, '0);
        #3;
        check("req17_start", mul_start, 1);
        check("req17_mul_b", mul_b, 32'h22);
        idle(2);
        drive(0, 6'h00, '0, '0, 1, 64'h242);
        drive(1, F_MFLO, '0, '0, 0, '0);
        #3;
        check("req17_lo", rd_data, 32'h242);

`ifndef HILO_SIGNED_MULT_EN
        // 6'h18 is unrecognised: no stall, no start
        drive(1, F_MULT, 32'h5, 32'h5, 0, '0);
        #3;
        check("req21_stall", stall, 0);
        drive(0, 6'h00, '0, '0, 0, '0);
        #3;
        check("req21_nostart", mul_start, 0);
`endif

        // Reset mid-WAIT, later done ignored
        drive(1, F_MULTU, 32'h9, 32'h9, 0, '0);
        idle(5);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        drive(0, 6'h00, '0, '0, 1, 64'hFFFF_0000_FFFF);
        drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("req28_hi", rd_data, 32'h0);
        check("req28_stall", stall, 0);
        drive(1, F_MFLO, '0, '0, 0, '0);
        #3;
        check("req28_lo", rd_data, 32'h0);

`ifdef HILO_SIGNED_MULT_EN
        // MULT -3 x 5
        drive(1, F_MULT, 32'hFFFF_FFFD, 32'h5, 0, '0);
        drive(0, 6'h00, '0, '0, 0, '0);
        #3;
        check("smul_a", mul_a, 32'h3);
        check("smul_b", mul_b, 32'h5);
        drive(0, 6'h00, '0, '0, 1, 64'd15);
        drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("smul_fix_stall", stall, 1);
        drive(1, F_MFHI, '0, '0, 0, '0);
        #3;
        check("smul_hi", rd_data, 32'hFFFF_FFFF);
        drive(1, F_MFLO, '0, '0, 0, '0);
        #3;
        check("smul_lo", rd_data, 32'hFFFF_FFF1);
        check("smul_model_lo", m_lo, 32'hFFFF_FFF1);
`endif

        // Randomised traffic
        done_pct = 20;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) done_pct = ($urandom_range(0, 2) == 0) ? 0 : 20;
            if ($urandom_range(0, 399) == 0) begin
                @(posedge clk); #1 reset = 1'b0;
                @(posedge clk); #1 reset = 1'b1;
            end
            f = fsel[$urandom_range(0, 6)];
            if (f == 6'h00) f = 6'($urandom);
            drive($urandom_range(0, 3) != 0, f, $urandom, $urandom,
                  $urandom_range(0, 99) < done_pct, {$urandom, $urandom});
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
